// File: rtl/ahbl_to_apb_bridge.sv
// ahbl_to_apb_bridge: AHB-Lite slave to APB master bridge.
// Each accepted AHB-Lite transfer becomes one APB SETUP/ACCESS sequence while the
// AHB data phase is stalled. The hart ID and PC sideband captured in the address
// phase are held on the APB side for the life of the transfer.
module ahbl_to_apb_bridge #(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ahbls_hready,
   output logic               ahbls_hready_resp,
   output logic               ahbls_hresp,
   input  logic [W_HADDR-1:0] ahbls_haddr,
   input  logic               ahbls_hwrite,
   input  logic [1:0]         ahbls_htrans,
   input  logic [W_DATA-1:0]  ahbls_hwdata,
   output logic [W_DATA-1:0]  ahbls_hrdata,
   input  logic [W_DATA-1:0]  ahbls_hartid,
   input  logic [W_PADDR-1:0] ahbls_pd_pc,
   output logic [W_PADDR-1:0] apbm_paddr,
   output logic               apbm_psel,
   output logic               apbm_penable,
   output logic               apbm_pwrite,
   output logic [W_DATA-1:0]  apbm_pwdata,
   input  logic               apbm_pready,
   input  logic               apbm_pslverr,
   input  logic [W_DATA-1:0]  apbm_prdata,
   output logic [W_DATA-1:0]  apbm_phartid,
   output logic [W_PADDR-1:0] apbm_pd_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_SETUP,
      S_ACCESS,
      S_RESP,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   access_done;

   // High address bits are decoded upstream and htrans[0] (SEQ vs NONSEQ) does not matter here.
   logic   unused_bits;
   assign unused_bits = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0]};

   // A new address phase can only be taken in states that present HREADYOUT high.
   assign accept = ahbls_hready && ahbls_htrans[1] &&
                   ((state == S_IDLE) || (state == S_RESP) || (state == S_ERR2));

   assign access_done = (state == S_ACCESS) && apbm_pready;

   // State register; reset drops straight to IDLE so psel falls asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the control outputs, all decoded from the current state.
   always_comb begin
      state_nxt         = state;
      ahbls_hready_resp = 1'b0;
      ahbls_hresp       = 1'b0;
      apbm_psel         = 1'b0;
      apbm_penable      = 1'b0;
      case (state)
         S_IDLE, S_RESP, S_ERR2: begin
            ahbls_hready_resp = 1'b1;
            ahbls_hresp       = (state == S_ERR2);
            if (accept) begin
               state_nxt = ahbls_hwrite ? S_WDATA : S_SETUP;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WDATA: begin
            state_nxt = S_SETUP;
         end
         S_SETUP: begin
            apbm_psel = 1'b1;
            state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            apbm_psel    = 1'b1;
            apbm_penable = 1'b1;
            if (apbm_pready) begin
               state_nxt = apbm_pslverr ? S_ERR1 : S_RESP;
            end
         end
         S_ERR1: begin
            ahbls_hresp = 1'b1;
            state_nxt   = S_ERR2;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Transfer attributes, write data and read data; each only moves at its own capture point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apbm_paddr   <= '0;
         apbm_pwrite  <= 1'b0;
         apbm_phartid <= '0;
         apbm_pd_pc   <= '0;
         apbm_pwdata  <= '0;
         ahbls_hrdata <= '0;
      end else begin
         if (accept) begin
            apbm_paddr   <= ahbls_haddr[W_PADDR-1:0];
            apbm_pwrite  <= ahbls_hwrite;
            apbm_phartid <= ahbls_hartid;
            apbm_pd_pc   <= ahbls_pd_pc;
         end
         if (state == S_WDATA) begin
            apbm_pwdata <= ahbls_hwdata;
         end
         if (access_done && !apbm_pslverr && !apbm_pwrite) begin
            ahbls_hrdata <= apbm_prdata;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// tb_ahbl_to_apb_bridge: drives AHB-Lite transfers into the bridge, models an APB
// slave with programmable wait states and error, and checks the APB side against
// a queue of expected transfers plus the AHB data-phase response.
module tb_ahbl_to_apb_bridge;

   logic        clk;
   logic        rst_n;
   logic        hready_in;
   logic        hready_block;
   logic        hready_resp;
   logic        hresp;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic [31:0] hartid;
   logic [15:0] pd_pc_in;
   logic [15:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;
   logic [31:0] phartid;
   logic [15:0] pd_pc_out;

   typedef struct {
      logic [15:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [31:0] hartid;
      logic [15:0] pc;
   } apb_exp_t;

   apb_exp_t    apbQ[$];
   int          vectorCount = 0;
   int          missCount   = 0;
   int          slaveWaits  = 0;
   logic        slaveErr    = 1'b0;
   logic [31:0] slaveRdata  = '0;
   int          waitCnt     = 0;
   logic [31:0] tbHrdata    = '0;

   // The bus-wide HREADY follows this slave unless the bench forces it low.
   assign hready_in = hready_block ? 1'b0 : hready_resp;

   ahbl_to_apb_bridge #(
      .W_HADDR(32),
      .W_PADDR(16),
      .W_DATA (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ahbls_hready     (hready_in),
      .ahbls_hready_resp(hready_resp),
      .ahbls_hresp      (hresp),
      .ahbls_haddr      (haddr),
      .ahbls_hwrite     (hwrite),
      .ahbls_htrans     (htrans),
      .ahbls_hwdata     (hwdata),
      .ahbls_hrdata     (hrdata),
      .ahbls_hartid     (hartid),
      .ahbls_pd_pc      (pd_pc_in),
      .apbm_paddr       (paddr),
      .apbm_psel        (psel),
      .apbm_penable     (penable),
      .apbm_pwrite      (pwrite),
      .apbm_pwdata      (pwdata),
      .apbm_pready      (pready),
      .apbm_pslverr     (pslverr),
      .apbm_prdata      (prdata),
      .apbm_phartid     (phartid),
      .apbm_pd_pc       (pd_pc_out)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backstop so a stuck bridge can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // APB slave model and APB-side scoreboard, both evaluated on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         pready  = 1'b0;
         pslverr = 1'b0;
         waitCnt = 0;
      end else if (psel) begin
         if (apbQ.size() == 0) begin
            checkOutput("apb_unexpected_psel", 32'(psel), 32'd0);
         end else begin
            checkOutput("paddr", 32'(paddr), 32'(apbQ[0].addr));
            checkOutput("pwrite", 32'(pwrite), 32'(apbQ[0].write));
            checkOutput("phartid", phartid, apbQ[0].hartid);
            checkOutput("pd_pc", 32'(pd_pc_out), 32'(apbQ[0].pc));
            if (apbQ[0].write) begin
               checkOutput("pwdata", pwdata, apbQ[0].wdata);
            end
         end
         if (penable) begin
            if (waitCnt >= slaveWaits) begin
               pready  = 1'b1;
               pslverr = slaveErr;
               prdata  = slaveRdata;
               if (apbQ.size() > 0) begin
                  void'(apbQ.pop_front());
               end
            end else begin
               pready  = 1'b0;
               pslverr = 1'b1;
               prdata  = 32'hBAD0BAD0;
               waitCnt++;
            end
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            waitCnt = 0;
         end
      end else begin
         pready  = 1'b1;
         pslverr = 1'b1;
         prdata  = 32'h0BAD0BAD;
         waitCnt = 0;
      end
   end

   // One AHB transfer: address phase here, then wait out the stalled data phase and check the response.
   task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                input logic [31:0] hid, input logic [15:0] pc, input int waits,
                                input logic err, input logic [31:0] rdata);
      apb_exp_t e;
      int       lowCnt;
      int       expLow;
      logic     lastLowHresp;
      slaveWaits = waits;
      slaveErr   = err;
      slaveRdata = rdata;
      e.addr   = addr[15:0];
      e.write  = write;
      e.wdata  = wdata;
      e.hartid = hid;
      e.pc     = pc;
      apbQ.push_back(e);
      haddr    = addr;
      hwrite   = write;
      htrans   = 2'b10;
      hartid   = hid;
      pd_pc_in = pc;
      hwdata   = 32'h5A5A5A5A;
      @(negedge clk);
      htrans   = 2'b00;
      haddr    = 32'hFFFFFFFF;
      hartid   = 32'hFFFFFFFF;
      pd_pc_in = 16'hFFFF;
      hwdata   = wdata;
      lowCnt       = 0;
      lastLowHresp = 1'b0;
      while (!hready_resp && lowCnt < 60) begin
         lowCnt++;
         lastLowHresp = hresp;
         @(negedge clk);
         hwdata = 32'hA5A5A5A5;
      end
      expLow = (write ? 3 : 2) + waits + (err ? 1 : 0);
      checkOutput("stall_cycles", 32'(lowCnt), 32'(expLow));
      checkOutput("err1_hresp", 32'(lastLowHresp), 32'(err));
      checkOutput("final_hresp", 32'(hresp), 32'(err));
      if (!write && !err) begin
         tbHrdata = rdata;
      end
      checkOutput("hrdata", hrdata, tbHrdata);
   endtask

   // Main sequence.
   initial begin
      rst_n        = 1'b0;
      hready_block = 1'b0;
      haddr        = '0;
      hwrite       = 1'b0;
      htrans       = 2'b00;
      hwdata       = '0;
      hartid       = '0;
      pd_pc_in     = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_hready_resp", 32'(hready_resp), 32'd1);
      checkOutput("rst_hresp", 32'(hresp), 32'd0);
      checkOutput("rst_hrdata", hrdata, 32'd0);
      checkOutput("rst_psel", 32'(psel), 32'd0);
      checkOutput("rst_penable", 32'(penable), 32'd0);
      checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
      checkOutput("rst_paddr", 32'(paddr), 32'd0);
      checkOutput("rst_pwdata", pwdata, 32'd0);
      checkOutput("rst_phartid", phartid, 32'd0);
      checkOutput("rst_pd_pc", 32'(pd_pc_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-wait read, stalled write, and an errored read that must leave hrdata alone.
      applyStimulus(32'h00001234, 1'b0, 32'h0, 32'h00000003, 16'h1000, 0, 1'b0, 32'hDEADBEEF);
      @(negedge clk);
      applyStimulus(32'h00000040, 1'b1, 32'hCAFEF00D, 32'h00000001, 16'h1004, 2, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(32'h00000200, 1'b0, 32'h0, 32'h00000002, 16'h1008, 0, 1'b1, 32'h11111111);

      // Read, then a write whose address phase lands in the read's RESP cycle.
      applyStimulus(32'h00000100, 1'b0, 32'h0, 32'h00000001, 16'h2000, 0, 1'b0, 32'h01234567);
      applyStimulus(32'h00000104, 1'b1, 32'h89ABCDEF, 32'h00000002, 16'h2004, 0, 1'b0, 32'h0);

      // Upper address bits are dropped.
      applyStimulus(32'hABCD5678, 1'b0, 32'h0, 32'h00000007, 16'h3000, 1, 1'b0, 32'h76543210);
      @(negedge clk);

      // Idle transfer and a NONSEQ qualified by HREADY low must both be ignored.
      htrans = 2'b00;
      haddr  = 32'h00000999;
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle_psel", 32'(psel), 32'd0);
         checkOutput("idle_hready_resp", 32'(hready_resp), 32'd1);
      end
      hready_block = 1'b1;
      htrans       = 2'b10;
      @(negedge clk);
      htrans       = 2'b00;
      hready_block = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("nohready_psel", 32'(psel), 32'd0);
         checkOutput("nohready_hready_resp", 32'(hready_resp), 32'd1);
      end

      // A handful of random transfers, some back-to-back, some errored.
      for (int i = 0; i < 6; i++) begin
         applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom, 16'($urandom),
                       int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom);
      end
      @(negedge clk);

      // Reset in the middle of ACCESS kills the transfer without a response.
      begin
         apb_exp_t e;
         int       k;
         slaveWaits = 10;
         slaveErr   = 1'b0;
         slaveRdata = 32'h99999999;
         e.addr   = 16'h0ACC;
         e.write  = 1'b0;
         e.wdata  = '0;
         e.hartid = 32'h00000004;
         e.pc     = 16'h4000;
         apbQ.push_back(e);
         haddr    = 32'h00000ACC;
         hwrite   = 1'b0;
         htrans   = 2'b10;
         hartid   = 32'h00000004;
         pd_pc_in = 16'h4000;
         @(negedge clk);
         htrans = 2'b00;
         k      = 0;
         while (!penable && k < 20) begin
            k++;
            @(negedge clk);
         end
         checkOutput("reached_access", 32'(penable), 32'd1);
         #2;
         rst_n = 1'b0;
         #1;
         checkOutput("arst_psel", 32'(psel), 32'd0);
         checkOutput("arst_penable", 32'(penable), 32'd0);
         checkOutput("arst_hready_resp", 32'(hready_resp), 32'd1);
         apbQ.delete();
         tbHrdata = '0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         checkOutput("post_rst_psel", 32'(psel), 32'd0);
      end
      applyStimulus(32'h00000ACC, 1'b0, 32'h0, 32'h00000005, 16'h4004, 0, 1'b0, 32'h13572468);
      @(negedge clk);
      checkOutput("apb_queue_empty", 32'(apbQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/ahbl_to_apb_bridge.md
# ahbl_to_apb_bridge

AHB-Lite slave to APB master bridge that sits directly upstream of the APB splitter. It carries processor peripheral accesses into the APB segment. Each AHB-Lite transfer is converted into one APB SETUP/ACCESS sequence, and the AHB data phase is stalled until the APB slave completes. The hart ID and program-counter sideband are captured alongside the address and driven to the splitter for the life of the APB transfer.

## Interface
Parameters:
- W_HADDR, 32, AHB address width
- W_PADDR, 16, APB address width; `apbm_paddr` and `apbm_pd_pc` width
- W_DATA, 32, data and hart-ID width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ahbls_hready  in  1  bus-wide HREADY; qualifies the address phase
- ahbls_hready_resp  out  1  this slave's HREADYOUT
- ahbls_hresp  out  1  1 = ERROR response
- ahbls_haddr  in  W_HADDR  address
- ahbls_hwrite  in  1  1 = write
- ahbls_htrans  in  2  only bit 1 is used (NONSEQ/SEQ = active)
- ahbls_hwdata  in  W_DATA  write data, valid in the data phase
- ahbls_hrdata  out  W_DATA  read data
- ahbls_hartid  in  W_DATA  hart ID, address-phase sideband
- ahbls_pd_pc  in  W_PADDR  PC sideband, address-phase
- apbm_paddr  out  W_PADDR  APB address
- apbm_psel, apbm_penable, apbm_pwrite  out  1 each  APB controls
- apbm_pwdata  out  W_DATA  APB write data
- apbm_pready, apbm_pslverr  in  1 each  APB slave responses
- apbm_prdata  in  W_DATA  APB read data
- apbm_phartid  out  W_DATA  hart ID held for the transfer
- apbm_pd_pc  out  W_PADDR  PC held for the transfer

## Operation
- **States:** IDLE, WDATA, SETUP, ACCESS, RESP, ERR1, ERR2.
- **Address capture:**
  - A transfer is accepted when `ahbls_hready && ahbls_htrans[1]` while in IDLE, RESP or ERR2.
  - On acceptance, register `haddr[W_PADDR-1:0]`, `hwrite`, `hartid` and `pd_pc`.
  - Next state is WDATA for a write, SETUP for a read.
  - In RESP or ERR2 with no accepted transfer, go to IDLE.
- **WDATA:** register `ahbls_hwdata` into `apbm_pwdata`, then go to SETUP.
- **SETUP:** `psel=1`, `penable=0`; go to ACCESS.
- **ACCESS:**
  - `psel=1`, `penable=1`; hold until `apbm_pready`.
  - On `pready` with `pslverr=0`: go to RESP; for reads, register `apbm_prdata` into `ahbls_hrdata`.
  - On `pready` with `pslverr=1`: go to ERR1. `hrdata` is not updated.
- **RESP:** `hready_resp=1`, `hresp=0`.
- **Error response (two cycles):**
  - ERR1: `hresp=1`, `hready_resp=0`.
  - ERR2: `hresp=1`, `hready_resp=1`.
- **hready_resp** is 1 in IDLE, RESP and ERR2, and 0 in all other states.
- **Stability:** `paddr`, `pwrite`, `pwdata`, `phartid` and `pd_pc` change only on address capture or WDATA. They are stable from SETUP through ACCESS completion.
- **Ignored inputs:**
  - `pready` and `pslverr` outside ACCESS.
  - `hwdata` outside WDATA.
  - Address-phase signals when `ahbls_hready=0`.
- **Width rule:** high address bits `haddr[W_HADDR-1:W_PADDR]` are discarded. Address decode is owned by the upstream fabric.
- **Reset mid-operation:** all state returns to IDLE and `psel` drops asynchronously. No response is generated for the aborted transfer.

## Timing
- **Reset values:**
  - `hready_resp=1`; `hresp=0`; `hrdata=0`.
  - `psel`, `penable`, `pwrite` = 0.
  - `paddr`, `pwdata`, `phartid`, `pd_pc` = 0.
  - State = IDLE.
- **Zero-wait read:**
  - T0: address phase.
  - T1: SETUP.
  - T2: ACCESS with `pready`.
  - T3: RESP with `hrdata` valid.
  - 3-cycle data phase.
- **Zero-wait write:**
  - T1: WDATA.
  - T2: SETUP.
  - T3: ACCESS.
  - T4: RESP.
  - 4-cycle data phase.
- **Wait states:** each cycle of `pready=0` in ACCESS adds one cycle.
- **Back-to-back transfers:** a transfer whose address phase coincides with RESP or ERR2 enters WDATA/SETUP on the next cycle, with no idle gap.
- **After ERR1:** the master may drive IDLE during ERR2. That cycle is an ordinary address phase.

## Test plan
- Read 0x1234 → `paddr=0x1234`; `psel` from T1; `penable` at T2. Slave returns 0xDEADBEEF with `pready=1` at T2 → `hready_resp=1` and `hrdata=0xDEADBEEF` at T3.
- Write 0x0040 with data 0xCAFEF00D, slave holds `pready=0` for 2 cycles → `pwdata=0xCAFEF00D`, stable through ACCESS; `hready_resp` low for exactly 5 cycles.
- Read with `pslverr=1` → ERR1 (`hresp=1`, `hready_resp=0`), then ERR2 (`hresp=1`, `hready_resp=1`); `hrdata` unchanged.
- Read followed immediately by a pipelined write (address in RESP) → write SETUP begins 2 cycles after RESP; `phartid` and `pd_pc` match each transfer's sideband.
- `htrans=IDLE`, or `htrans=NONSEQ` with `ahbls_hready=0` → no `psel`; bridge stays IDLE.
- `rst_n` asserted during ACCESS → `psel=0` and `penable=0` immediately; `hready_resp=1` after reset; a subsequent read completes normally.
